// File: rtl/hqm_rcfwl_gclk_psocsync_tracker.sv
// PSoC sync tracker: aligns a free-running local phase counter to the distributed
// sync pulse, declares lock after NUM_LOCK on-time pulses, then emits clk_en at phase 0.
module hqm_rcfwl_gclk_psocsync_tracker #(
  parameter int RATIO_W  = 4,
  parameter int NUM_LOCK = 3
) (
  input  logic               adop_postclk_free,
  input  logic               rst_b,
  input  logic               sync_in,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               err_clr,
  output logic [RATIO_W-1:0] phase,
  output logic               locked,
  output logic               clk_en,
  output logic               sync_err
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] phase_q, phase_d, last_ph, phase_inc;
  logic [3:0]         good_q, good_d;
  logic [4:0]         good_nxt;
  logic               err_q, err_set, locked_q, clk_en_q;
  logic               at_end, good, early, missing;

  // Ratios below 2 collapse to R=2, so the last phase is never below 1.
  assign last_ph   = (ratio < RATIO_W'(2)) ? RATIO_W'(1) : ratio - RATIO_W'(1);
  assign at_end    = (phase_q == last_ph);
  assign phase_inc = (phase_q >= last_ph) ? '0 : phase_q + RATIO_W'(1);
  assign good_nxt  = {1'b0, good_q} + 5'd1;

  assign good    =  sync_in &  at_end;
  assign early   =  sync_in & ~at_end;
  assign missing = ~sync_in &  at_end;

  always_comb begin
    state_d = state_q;
    phase_d = phase_inc;
    good_d  = good_q;
    err_set = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      phase_d = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d = '0;
          if (sync_in) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        ACQUIRE: begin
          if (good) begin
            good_d = good_nxt[3:0];
            if (good_nxt == 5'(NUM_LOCK)) state_d = LOCKED;
          end else if (early) begin
            good_d  = '0;
            phase_d = '0;
          end else if (missing) begin
            state_d = IDLE;
            good_d  = '0;
            phase_d = '0;
          end
        end
        LOCKED: begin
          // A missing pulse lets phase wrap naturally; an early one realigns.
          if (early || missing) begin
            err_set = 1'b1;
            state_d = ACQUIRE;
            good_d  = '0;
            if (early) phase_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge adop_postclk_free or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      clk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      locked_q <= (state_d == LOCKED);
      clk_en_q <= (state_d == LOCKED) && (phase_d == '0);
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  assign phase    = phase_q;
  assign locked   = locked_q;
  assign clk_en   = clk_en_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_psocsync_tracker.sv
// Scoreboard bench for the PSoC sync tracker: a cycle model pushes expected outputs
// per edge, popped after the edge; directed checks pin the key timeline points.
module tb_hqm_rcfwl_gclk_psocsync_tracker;
  localparam int RW = 4;
  localparam int NL = 3;

  logic          gclk = 1'b0;
  logic          rst_b = 1'b0;
  logic          sync_in = 1'b0, enable = 1'b0, err_clr = 1'b0;
  logic [RW-1:0] ratio = 4'd4;
  logic [RW-1:0] phase;
  logic          locked, clk_en, sync_err;

  hqm_rcfwl_gclk_psocsync_tracker #(.RATIO_W(RW), .NUM_LOCK(NL)) dut (
    .adop_postclk_free(gclk), .rst_b(rst_b), .sync_in(sync_in), .enable(enable),
    .ratio(ratio), .err_clr(err_clr), .phase(phase), .locked(locked),
    .clk_en(clk_en), .sync_err(sync_err)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [RW-1:0] ph;
    logic          lk;
    logic          ce;
    logic          er;
  } obs_t;

  obs_t expq[$];
  int   nvec = 0, nerr = 0;
  int   m_st = 0, m_ph = 0, m_gc = 0;
  bit   m_er = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level model: state 0=IDLE 1=ACQUIRE 2=LOCKED, evaluated at the coming edge.
  task automatic model_step();
    int r;
    bit last, set;
    r    = (ratio < 2) ? 2 : int'(ratio);
    last = (m_ph == r - 1);
    set  = 1'b0;
    if (!enable) begin
      m_st = 0; m_ph = 0; m_gc = 0;
    end else if (m_st == 0) begin
      m_ph = 0;
      if (sync_in) begin m_st = 1; m_gc = 0; end
    end else if (m_st == 1) begin
      if (sync_in && last) begin
        m_gc++; m_ph = 0;
        if (m_gc == NL) m_st = 2;
      end else if (sync_in) begin m_gc = 0; m_ph = 0; end
      else if (last) begin m_st = 0; m_gc = 0; m_ph = 0; end
      else m_ph++;
    end else begin
      if (sync_in && last) m_ph = 0;
      else if (sync_in || last) begin set = 1'b1; m_st = 1; m_gc = 0; m_ph = 0; end
      else m_ph++;
    end
    if (set) m_er = 1'b1;
    else if (err_clr) m_er = 1'b0;
    expq.push_back('{ph: RW'(m_ph), lk: (m_st == 2), ce: (m_st == 2 && m_ph == 0), er: m_er});
  endtask

  task automatic cyc(input bit s, input bit c = 1'b0);
    obs_t e, g;
    sync_in = s; err_clr = c;
    model_step();
    @(posedge gclk); #1;
    g = '{ph: phase, lk: locked, ce: clk_en, er: sync_err};
    if (expq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = expq.pop_front();
      chk("sb", 32'(g), 32'(e));
    end
    sync_in = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic lock_seq(input int r);
    cyc(1'b1);
    for (int k = 0; k < NL; k++) begin idle(r - 1); cyc(1'b1); end
  endtask

  initial begin
    #2;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_flags", {29'd0, locked, clk_en, sync_err}, 32'd0);
    @(negedge gclk); rst_b = 1'b1;

    // Basic lock, R=4: pulses at cycles 10,14,18,22
    enable = 1'b1; ratio = 4'd4;
    idle(9);
    cyc(1'b1);
    chk("align_ph0", 32'(phase), 32'd0);
    cyc(1'b0);
    chk("align_ph1", 32'(phase), 32'd1);
    idle(2); cyc(1'b1);
    idle(3); cyc(1'b1);
    chk("prelock", 32'(locked), 32'd0);
    idle(3); cyc(1'b1);
    chk("lock_rise", {30'd0, locked, clk_en}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0); chk("ce_low", 32'(clk_en), 32'd0);
      idle(2); cyc(1'b1); chk("ce_period", 32'(clk_en), 32'd1);
    end
    chk("no_err", 32'(sync_err), 32'd0);

    // Early pulse in LOCKED, then relock with sync_err sticky
    cyc(1'b0); cyc(1'b1);
    chk("early_flags", {29'd0, locked, clk_en, sync_err}, 32'd1);
    chk("early_ph", 32'(phase), 32'd0);
    for (int k = 0; k < NL; k++) begin idle(3); cyc(1'b1); end
    chk("relock", {30'd0, locked, sync_err}, 32'd3);
    cyc(1'b0, 1'b1);
    chk("err_clr", 32'(sync_err), 32'd0);

    // Missing in LOCKED with coincident err_clr, then missing in ACQUIRE
    idle(2); cyc(1'b0, 1'b1);
    chk("miss_lk", {30'd0, locked, sync_err}, 32'd1);
    idle(4);
    idle(5);
    chk("idle_ph", 32'(phase), 32'd0);
    lock_seq(4);
    chk("miss_relock", 32'(locked), 32'd1);

    // Disable coincident with a good pulse; sync_err retained
    idle(3); enable = 1'b0; cyc(1'b1);
    chk("dis_flags", {29'd0, locked, clk_en, sync_err}, 32'd1);
    chk("dis_ph", 32'(phase), 32'd0);
    cyc(1'b1); idle(3); cyc(1'b1);
    chk("dis_hold", 32'(locked), 32'd0);
    cyc(1'b0, 1'b1);
    chk("dis_clr", 32'(sync_err), 32'd0);

    // ratio=1 behaves as R=2; early at phase 0 and held pulse
    ratio = 4'd1; enable = 1'b1;
    lock_seq(2);
    chk("r2_lock", 32'(locked), 32'd1);
    idle(1); cyc(1'b1); cyc(1'b1);
    chk("r2_early", {30'd0, locked, sync_err}, 32'd1);
    cyc(1'b1); cyc(1'b1);
    idle(3);

    // ratio=15 lock path, then async reset mid-LOCKED
    enable = 1'b0; cyc(1'b0, 1'b1);
    ratio = 4'd15; enable = 1'b1;
    lock_seq(15);
    chk("r15_lock", {30'd0, locked, clk_en}, 32'd3);
    idle(6);
    #2; rst_b = 1'b0; #1;
    chk("arst_ph", 32'(phase), 32'd0);
    chk("arst_flags", {29'd0, locked, clk_en, sync_err}, 32'd0);
    m_st = 0; m_ph = 0; m_gc = 0; m_er = 1'b0;
    expq.delete();
    @(negedge gclk); rst_b = 1'b1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/hqm_rcfwl_gclk_psocsync_tracker.md
# hqm_rcfwl_gclk_psocsync_tracker

Consumes one lane of the distributed PSoC sync pulse, after the repeater flop chain in the adop_postclk_free domain. Builds a free-running local phase counter aligned to that pulse. Declares lock after a programmable number of on-time pulses and then issues a one-cycle clock-enable at phase 0. Flags early or missing pulses as a sticky error and re-acquires alignment without software help.

## Interface
- RATIO_W, 4, width of the ratio input and the phase counter.
- NUM_LOCK, 3, consecutive on-time sync pulses required in ACQUIRE before entering LOCKED (legal range 1..15).
- adop_postclk_free  in  1  free-running post-gated clock; the only clock.
- rst_b  in  1  asynchronous, active-low reset.
- sync_in  in  1  distributed sync pulse, already synchronous to adop_postclk_free.
- enable  in  1  tracker enable; level.
- ratio  in  RATIO_W  expected sync period in cycles; values below 2 are treated as 2; changed only while enable=0.
- err_clr  in  1  one-cycle pulse that clears sync_err.
- phase  out  RATIO_W  cycles elapsed since the last alignment point, 0..R-1 (R = effective ratio).
- locked  out  1  high while the state is LOCKED.
- clk_en  out  1  one-cycle enable, high when locked and phase==0.
- sync_err  out  1  sticky: an early or missing pulse was seen in LOCKED.

## Operation
- States: IDLE, ACQUIRE, LOCKED. good_cnt is a 4-bit count of consecutive on-time pulses.
- Pulse classification at each edge (ACQUIRE and LOCKED only):
  - good = sync_in & (phase==R-1)
  - early = sync_in & (phase!=R-1)
  - missing = ~sync_in & (phase==R-1)
- Phase update:
  - phase increments each cycle and wraps from R-1 to 0.
  - early forces phase to 0.
  - In IDLE, phase is held at 0.
- IDLE:
  - enable & sync_in: go to ACQUIRE, phase=0, good_cnt=0.
  - Otherwise stay in IDLE.
- ACQUIRE:
  - good: good_cnt+1. When good_cnt+1==NUM_LOCK, go to LOCKED.
  - early: good_cnt=0, phase=0, stay in ACQUIRE.
  - missing: go to IDLE, good_cnt=0.
- LOCKED:
  - good: no action.
  - early or missing: set sync_err, go to ACQUIRE, good_cnt=0.
  - early also realigns phase to 0. missing lets phase wrap normally.
- enable=0 in any state: next state is IDLE, phase=0, good_cnt=0. This has priority over every pulse event. sync_err is kept.
- sync_err:
  - set by an error event, cleared by err_clr.
  - Set and clear in the same cycle: set wins.
  - Errors in ACQUIRE never set sync_err.
- All outputs are flop outputs. There is no combinational path from any input to any output.
- clk_en is registered so that it is high exactly in the cycles where state==LOCKED and phase==0.

## Timing
- Reset values: phase=0, locked=0, clk_en=0, sync_err=0, state=IDLE, good_cnt=0.
- Alignment latency: a sync_in sampled at edge t gives phase=0 after edge t and phase=1 after edge t+1.
- Lock latency: the first pulse at edge t0 is followed by good pulses at t0+R·k, k=1..NUM_LOCK. locked and clk_en both rise after edge t0+NUM_LOCK·R.
- In LOCKED, clk_en has a period of exactly R cycles and a width of 1 cycle.
- Loss of lock: locked and clk_en fall in the cycle after the offending edge. sync_err rises in the same cycle.
- R=2 boundary: phase toggles between 0 and 1, and every phase==1 cycle needs a pulse. A pulse at phase 0 is early.
- Maximum R is 2^RATIO_W-1. ratio=0 or ratio=1 behaves as R=2.
- A pulse that is held high for more than one cycle counts as early on its second cycle.

## Test plan
- Basic lock: R=4, NUM_LOCK=3, enable=1, pulses at cycles 10, 14, 18, 22 -> locked rises after edge 22; clk_en is high at cycles 23, 27, 31; phase sequence is 0,1,2,3; sync_err stays 0.
- Early pulse in LOCKED: after lock, a pulse 2 cycles early -> sync_err=1 and locked=0 next cycle, phase=0; three further on-time pulses relock; sync_err stays 1 until err_clr.
- Missing pulse in LOCKED, then in ACQUIRE: drop one pulse -> sync_err=1 and state ACQUIRE; drop the next pulse too -> state IDLE, phase held at 0, and the next pulse restarts acquisition.
- Disable mid-lock: enable=0 coincident with a good pulse -> next cycle locked=0, clk_en=0, phase=0, IDLE; sync_err unchanged.
- err_clr coincident with a new error -> sync_err stays 1; err_clr alone -> sync_err becomes 0 next cycle.
- Boundaries: ratio=1 (acts as R=2) with pulses every 2 cycles -> lock after 3 good pulses; ratio=15 lock path; async rst_b asserted mid-LOCKED -> all outputs go to 0 immediately, with no clock edge needed.
